node_min_scheduler: RTL and testbench
=====================================

# node_min_scheduler

Sequential scheduler for the path-planner node-cost table. It holds 32 7-bit node costs and a visited mask, and accepts cost writes, including min-relax writes. On request it scans the table and returns the lowest-cost unvisited node, then marks that node visited when the result is taken. It sits between the planner FSM and the cost datapath and serialises all access to the cost table.

## Interface
Parameters:
- N_NODES, 32, number of table entries (index width IDX_W = 5)
- COST_W, 7, cost width; all-ones (127) means infinity/unreachable

Ports:
- clk_50M  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset
- clear  in  1  one-cycle pulse: all costs to 127, visited mask to 0 (IDLE only)
- load_valid  in  1  cost write request
- load_ready  out  1  write accepted when load_valid and load_ready are both high
- load_idx  in  5  entry to write
- load_cost  in  7  new cost
- load_relax  in  1  1: store min(old, new); 0: overwrite
- req_valid  in  1  request for the minimum unvisited entry
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid and res_ready are both high
- res_idx  out  5  index of the selected entry
- res_cost  out  7  cost of the selected entry
- res_none  out  1  no unvisited entry with cost below 127
- busy  out  1  high in SCAN and HOLD

## Operation
- States:
  - IDLE: accepts clear, loads and requests.
  - SCAN: 32 cycles, one entry compared per cycle, index 0 to 31.
  - HOLD: result presented until handshake.
- Transitions:
  - IDLE to SCAN on accepted request.
  - SCAN to HOLD after entry 31 is compared.
  - HOLD to IDLE on result handshake.
- load_ready = req_ready = (state == IDLE) && !clear.
- clear has priority over load and req in the same cycle; both are ignored (ready low).
- Load and request accepted in the same cycle: the write commits first, and the scan sees the new value.
- Writes to a visited entry are accepted and dropped; the table is unchanged.
- Relax write stores new only if new < stored (unsigned); equal values leave the entry unchanged.
- Scan candidate rule: entry not visited and cost != 127.
  - Running best is replaced only on strictly smaller cost, so the lowest index wins ties.
- End of scan with no candidate: res_none=1, res_idx=0, res_cost=127.
- Result handshake with res_none=0: visited[res_idx] set in that same cycle. With res_none=1 the mask is unchanged.
- Cost table and visited mask are only modified by reset, clear, accepted loads, and the result handshake.

## Timing
- Reset values:
  - all costs 127; visited = 0; state IDLE
  - res_valid=0, res_idx=0, res_cost=127, res_none=0, busy=0
  - load_ready=1, req_ready=1 (when clear low)
- Latency: request accepted on edge T, so busy=1 from T+1. Last compare is at edge T+32, and res_valid=1 from T+33.
- Results are registered. res_idx, res_cost and res_none are stable while res_valid=1 and res_ready=0 (unlimited backpressure).
- res_valid falls on the edge after the handshake, and the state returns to IDLE on that edge. The next request can be accepted in the cycle after the handshake.
- Loads issued during SCAN/HOLD are not accepted (load_ready=0). The source must hold them.
- clear takes effect on the edge where it is sampled, and the next cycle shows the cleared table.
- reset asserted in any state (including mid-scan or HOLD) restores all reset values on the next edge. Any partial scan is discarded.

## Test plan
- Reset, then request with an empty table: busy high for 33 cycles. Then res_valid=1, res_none=1, res_idx=0, res_cost=127, and the mask is unchanged after the handshake.
- Load cost[i]=100-i for i=0..31, then request: result idx 31, cost 69 at T+33. Handshake, then request again: idx 30, cost 70.
- Ties: cost[5]=3, cost[20]=3, all others 127. First result idx 5, second idx 20, third res_none=1.
- Relax rules on idx 7:
  - plain write 50, then relax 60: entry stays 50.
  - relax 40: entry becomes 40.
  - plain write 90: entry becomes 90.
  - pop idx 7, then write 10 to idx 7: write dropped, next result res_none=1.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid. Outputs stay constant, load_ready=0, and visited is unchanged until the handshake.
- Reset asserted 10 cycles into a scan: the next cycle shows state IDLE, res_valid=0, busy=0, and all costs 127 (a subsequent request returns res_none=1). Also check clear together with load_valid: the load is not accepted and the table is fully cleared.

Source files
------------

// File: rtl/node_min_scheduler.sv
// Sequential min-cost scheduler over a 32-entry node-cost table with a visited mask.
// Cost writes (plain or min-relax) are taken in IDLE; a request scans one entry per cycle.
module node_min_scheduler #(
    parameter int N_NODES = 32,
    parameter int COST_W  = 7,
    localparam int IDX_W  = $clog2(N_NODES)
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [COST_W-1:0] load_cost,
    input  logic              load_relax,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [COST_W-1:0] res_cost,
    output logic              res_none,
    output logic              busy
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [COST_W-1:0] COST_INF = '1;
    localparam logic [CNT_W-1:0]  SCAN_END = CNT_W'(N_NODES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    logic [COST_W-1:0]   cost_mem [N_NODES];
    logic [N_NODES-1:0]  visited;
    logic [CNT_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    best_idx;
    logic [COST_W-1:0]   best_cost;

    assign scan_idx   = scan_cnt[IDX_W-1:0];
    assign load_ready = (state == IDLE) && !clear;
    assign req_ready  = (state == IDLE) && !clear;

    // Every table entry gets a defined value on reset, so the table is built from
    // flops rather than a RAM macro; the scan reads one entry per cycle anyway.
    always_ff @(posedge clk_50M) begin
        // NOTE: all state here uses non-blocking assignments so every branch reads
        // the pre-edge values, e.g. the scan compares against the old best_cost.
        if (reset) begin
            state     <= IDLE;
            visited   <= '0;
            scan_cnt  <= '0;
            best_idx  <= '0;
            best_cost <= COST_INF;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_cost  <= COST_INF;
            res_none  <= 1'b0;
            busy      <= 1'b0;
            // NOTE: resetting the table means looping over every entry; this only
            // works because the table is registers, not an inferred memory.
            for (int i = 0; i < N_NODES; i++) begin
                cost_mem[i] <= COST_INF;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        visited <= '0;
                        for (int i = 0; i < N_NODES; i++) begin
                            cost_mem[i] <= COST_INF;
                        end
                    end else begin
                        // Visited entries are frozen; relax keeps the smaller value.
                        if (load_valid && !visited[load_idx]) begin
                            if (!load_relax || (load_cost < cost_mem[load_idx])) begin
                                cost_mem[load_idx] <= load_cost;
                            end
                        end
                        if (req_valid) begin
                            state     <= SCAN;
                            busy      <= 1'b1;
                            scan_cnt  <= '0;
                            best_idx  <= '0;
                            best_cost <= COST_INF;
                        end
                    end
                end

                SCAN: begin
                    if (scan_cnt == SCAN_END) begin
                        state     <= HOLD;
                        res_valid <= 1'b1;
                        res_idx   <= best_idx;
                        res_cost  <= best_cost;
                        res_none  <= (best_cost == COST_INF);
                    end else begin
                        // Strict less-than: infinite entries never win, ties keep the lower index.
                        if (!visited[scan_idx] && (cost_mem[scan_idx] < best_cost)) begin
                            best_idx  <= scan_idx;
                            best_cost <= cost_mem[scan_idx];
                        end
                        scan_cnt <= scan_cnt + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        if (!res_none) begin
                            visited[res_idx] <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_min_scheduler.sv
// Scoreboard bench for node_min_scheduler: stimulus queues expected results,
// a negedge monitor compares them on each result handshake.
module tb_node_min_scheduler;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       clear;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_idx;
    logic [6:0] load_cost;
    logic       load_relax;
    logic       req_valid;
    logic       req_ready;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_idx;
    logic [6:0] res_cost;
    logic       res_none;
    logic       busy;

    always #10 clk_50M = ~clk_50M;

    node_min_scheduler dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_cost  (load_cost),
        .load_relax (load_relax),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_idx    (res_idx),
        .res_cost   (res_cost),
        .res_none   (res_none),
        .busy       (busy)
    );

    typedef struct {
        int idx;
        int cost;
        int none;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    always @(negedge clk_50M) begin
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got idx %0d cost %0d with nothing queued", res_idx, res_cost);
            end else begin
                mon_e = sb.pop_front();
                check("res_idx", res_idx, mon_e.idx);
                check("res_cost", res_cost, mon_e.cost);
                check("res_none", res_none, mon_e.none);
            end
        end
    end

    task automatic do_load(input int idx, input int c, input bit relax);
        int w;
        w = 0;
        load_valid = 1'b1;
        load_idx   = idx[4:0];
        load_cost  = c[6:0];
        load_relax = relax;
        while (!load_ready && w < 100) begin
            step();
            w++;
        end
        if (!load_ready) check("load_ready_timeout", load_ready, 1);
        step();
        load_valid = 1'b0;
        load_relax = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("load_ready_during_clear", load_ready, 0);
        check("req_ready_during_clear", req_ready, 0);
        step();
        clear = 1'b0;
    endtask

    task automatic do_req(input int ei, input int ec, input int en, input int hold);
        int lat;
        sb.push_back('{ei, ec, en});
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("load_ready_in_scan", load_ready, 0);
        lat = 0;
        while (!res_valid && lat < 100) begin
            step();
            lat++;
        end
        check("result_latency", lat, 33);
        check("busy_in_hold", busy, 1);
        for (int k = 0; k < hold; k++) begin
            check("hold_valid", res_valid, 1);
            check("hold_idx", res_idx, ei);
            check("hold_cost", res_cost, ec);
            check("hold_none", res_none, en);
            check("hold_load_ready", load_ready, 0);
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("res_valid_after_hs", res_valid, 0);
        check("busy_after_hs", busy, 0);
        check("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_idx   = '0;
        load_cost  = '0;
        load_relax = 1'b0;
        req_valid  = 1'b0;
        res_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_res_valid", res_valid, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_res_cost", res_cost, 127);
        check("rst_res_none", res_none, 0);
        check("rst_busy", busy, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_req_ready", req_ready, 1);

        // Empty table: no candidate, and the mask stays untouched.
        do_req(0, 127, 1, 0);
        do_load(0, 9, 1'b0);
        do_req(0, 9, 0, 0);

        // Descending costs: highest index is cheapest.
        do_clear();
        for (int i = 0; i < 32; i++) do_load(i, 100 - i, 1'b0);
        do_req(31, 69, 0, 0);
        do_req(30, 70, 0, 0);

        // Ties resolve to the lower index; first result held under backpressure.
        do_clear();
        do_load(5, 3, 1'b0);
        do_load(20, 3, 1'b0);
        do_req(5, 3, 0, 10);
        do_req(20, 3, 0, 0);
        do_req(0, 127, 1, 0);

        // Relax rules on entry 7.
        do_clear();
        do_load(7, 50, 1'b0);
        do_load(7, 60, 1'b1);
        do_req(7, 50, 0, 0);
        do_clear();
        do_load(7, 50, 1'b0);
        do_load(7, 50, 1'b1);
        do_load(7, 40, 1'b1);
        do_req(7, 40, 0, 0);
        do_clear();
        do_load(7, 50, 1'b0);
        do_load(7, 40, 1'b1);
        do_load(7, 90, 1'b0);
        do_req(7, 90, 0, 0);
        do_load(7, 10, 1'b0);
        do_req(0, 127, 1, 0);

        // Reset ten cycles into a scan discards it and restores the table.
        do_load(3, 5, 1'b0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (10) step();
        check("midscan_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midscan_rst_busy", busy, 0);
        check("midscan_rst_res_valid", res_valid, 0);
        check("midscan_rst_res_cost", res_cost, 127);
        check("midscan_rst_res_idx", res_idx, 0);
        check("midscan_rst_load_ready", load_ready, 1);
        do_req(0, 127, 1, 0);

        // Clear beats a simultaneous load and also wipes the visited mask.
        do_load(2, 8, 1'b0);
        do_req(2, 8, 0, 0);
        do_load(11, 6, 1'b0);
        load_valid = 1'b1;
        load_idx   = 5'd9;
        load_cost  = 7'd4;
        do_clear();
        load_valid = 1'b0;
        do_load(2, 12, 1'b0);
        do_req(2, 12, 0, 0);
        do_req(0, 127, 1, 0);

        step();
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
